// File: rtl/skipped_lv1_tmr_bank_pkg.sv
// Shared helpers for the skipped-LV1 TMR counter bank: bitwise majority vote
// and the saturation value for a given counter width.
package skipped_lv1_tmr_bank_pkg;

    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] maj3(input logic [MAX_W-1:0] a,
                                              input logic [MAX_W-1:0] b,
                                              input logic [MAX_W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // All-ones value of a w-bit counter, for w in 1..MAX_W.
    function automatic logic [MAX_W-1:0] cnt_max(input int w);
        return {MAX_W{1'b1}} >> (MAX_W - w);
    endfunction

endpackage

// File: rtl/skipped_lv1_tmr_bank_if.sv
// Trigger, read-out and SEU-status signals of the skipped-LV1 counter bank.
interface skipped_lv1_tmr_bank_if #(
    parameter int CNT_W = 8,
    parameter int N_CH  = 4,
    parameter int CH_W  = 2
);
    logic             L1;
    logic [N_CH-1:0]  L1_Reg_Full;
    logic             ReadReq;
    logic [CH_W-1:0]  ReadCh;
    logic             ReadValid;
    logic [CNT_W-1:0] ReadData;
    logic             ReadSat;
    logic             SkippedAny;
    logic             SeuPulse;
    logic             SeuFlag;
    logic             SeuClear;

    modport master (
        output L1, L1_Reg_Full, ReadReq, ReadCh, SeuClear,
        input  ReadValid, ReadData, ReadSat, SkippedAny, SeuPulse, SeuFlag
    );

    modport slave (
        input  L1, L1_Reg_Full, ReadReq, ReadCh, SeuClear,
        output ReadValid, ReadData, ReadSat, SkippedAny, SeuPulse, SeuFlag
    );
endinterface

// File: rtl/skipped_lv1_tmr_bank_tmr_sat_counter.sv
// One triplicated saturating counter. All copies reload the voted next value
// every cycle, so a single-copy upset lives for at most one cycle.
module tmr_sat_counter
    import skipped_lv1_tmr_bank_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             skip,
    input  logic             clear,
    output logic [CNT_W-1:0] voted,
    output logic             mismatch
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] copy0_q, copy1_q, copy2_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        voted    = CNT_W'(maj3(MAX_W'(copy0_q), MAX_W'(copy1_q), MAX_W'(copy2_q)));
        mismatch = (copy0_q != copy1_q) || (copy1_q != copy2_q);
    end

    // A skip coinciding with the clearing read starts the new count at one.
    always_comb begin
        cnt_d = voted;
        if (clear && skip) begin
            cnt_d = CNT_W'(1);
        end else if (clear) begin
            cnt_d = '0;
        end else if (skip) begin
            cnt_d = (voted == CNT_MAX) ? voted : voted + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copy0_q <= '0;
            copy1_q <= '0;
            copy2_q <= '0;
        end else begin
            copy0_q <= cnt_d;
            copy1_q <= cnt_d;
            copy2_q <= cnt_d;
        end
    end

endmodule

// File: rtl/skipped_lv1_tmr_bank.sv
// Bank of N_CH TMR skipped-trigger counters with a read-and-clear port and
// a scrub-mismatch (SEU) monitor.
module skipped_lv1_tmr_bank
    import skipped_lv1_tmr_bank_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int N_CH  = 4,
    parameter int CH_W  = 2
) (
    input logic                   Clk,
    input logic                   Reset,
    skipped_lv1_tmr_bank_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [N_CH-1:0]  skip;
    logic [N_CH-1:0]  clear;
    logic [N_CH-1:0]  mismatch;
    logic [CNT_W-1:0] voted [N_CH];

    logic             read_valid_d, read_valid_q;
    logic [CNT_W-1:0] read_data_d, read_data_q;
    logic             read_sat_d, read_sat_q;
    logic             seu_pulse_d, seu_pulse_q;
    logic             seu_flag_d, seu_flag_q;
    logic             skipped_any;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign skip[c]  = bus.L1 & bus.L1_Reg_Full[c];
        assign clear[c] = bus.ReadReq && (bus.ReadCh == CH_W'(c));

        tmr_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk      (Clk),
            .rst_n    (Reset),
            .skip     (skip[c]),
            .clear    (clear[c]),
            .voted    (voted[c]),
            .mismatch (mismatch[c])
        );
    end

    // Out-of-range channels read as zero; data holds between reads.
    always_comb begin
        read_valid_d = bus.ReadReq;
        read_data_d  = read_data_q;
        read_sat_d   = read_sat_q;
        if (bus.ReadReq) begin
            read_data_d = '0;
            for (int c = 0; c < N_CH; c++) begin
                if (bus.ReadCh == CH_W'(c)) begin
                    read_data_d = voted[c];
                end
            end
            read_sat_d = (read_data_d == CNT_MAX);
        end
    end

    always_comb begin
        seu_pulse_d = |mismatch;
        seu_flag_d  = (|mismatch) ? 1'b1 : (bus.SeuClear ? 1'b0 : seu_flag_q);
        skipped_any = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            skipped_any = skipped_any | (voted[c] != '0);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            read_valid_q <= 1'b0;
            read_data_q  <= '0;
            read_sat_q   <= 1'b0;
            seu_pulse_q  <= 1'b0;
            seu_flag_q   <= 1'b0;
        end else begin
            read_valid_q <= read_valid_d;
            read_data_q  <= read_data_d;
            read_sat_q   <= read_sat_d;
            seu_pulse_q  <= seu_pulse_d;
            seu_flag_q   <= seu_flag_d;
        end
    end

    assign bus.ReadValid  = read_valid_q;
    assign bus.ReadData   = read_data_q;
    assign bus.ReadSat    = read_sat_q;
    assign bus.SkippedAny = skipped_any;
    assign bus.SeuPulse   = seu_pulse_q;
    assign bus.SeuFlag    = seu_flag_q;

endmodule

// File: tb/tb_skipped_lv1_tmr_bank.sv
// Randomised and directed bench for skipped_lv1_tmr_bank against a per-channel
// integer count model.
module tb_skipped_lv1_tmr_bank;

    localparam int CNT_W = 8;
    localparam int N_CH  = 4;
    localparam int CH_W  = 2;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    skipped_lv1_tmr_bank_if #(.CNT_W(CNT_W), .N_CH(N_CH), .CH_W(CH_W)) bus ();

    skipped_lv1_tmr_bank #(.CNT_W(CNT_W), .N_CH(N_CH), .CH_W(CH_W)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    int checks;
    int failures;

    int cnt [N_CH];
    int expData;
    bit expSat;
    bit expValid;
    bit expPulse;
    bit expFlag;
    logic [CNT_W-1:0] injVal;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic bit anyNonZero();
        bit r = 1'b0;
        for (int c = 0; c < N_CH; c++) r |= (cnt[c] != 0);
        return r;
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, ".valid"}, 32'(bus.ReadValid), 32'(expValid));
        checkOutput({tag, ".data"}, 32'(bus.ReadData), 32'(expData));
        checkOutput({tag, ".sat"}, 32'(bus.ReadSat), 32'(expSat));
        checkOutput({tag, ".any"}, 32'(bus.SkippedAny), 32'(anyNonZero()));
        checkOutput({tag, ".pulse"}, 32'(bus.SeuPulse), 32'(expPulse));
        checkOutput({tag, ".flag"}, 32'(bus.SeuFlag), 32'(expFlag));
    endtask

    // One clock cycle: drive inputs, optionally upset copy 1 bit 3 of ch3, update the model.
    task automatic applyStimulus(input string tag, input bit l1, input logic [N_CH-1:0] full,
                                 input bit req, input int ch, input bit seuClr, input bit inject);
        bit s;
        bit k;
        @(negedge clk);
        bus.L1          = l1;
        bus.L1_Reg_Full = full;
        bus.ReadReq     = req;
        bus.ReadCh      = CH_W'(ch);
        bus.SeuClear    = seuClr;
        if (inject) begin
            injVal = CNT_W'(cnt[3]) ^ CNT_W'(8);
            #1 force dut.g_ch[3].u_cnt.copy1_q = injVal;
            #1 release dut.g_ch[3].u_cnt.copy1_q;
        end
        @(posedge clk);
        expValid = req;
        if (req) begin
            expData = (ch < N_CH) ? cnt[ch] : 0;
            expSat  = (expData == MAXV);
        end
        for (int c = 0; c < N_CH; c++) begin
            s = l1 && full[c];
            k = req && (ch == c);
            if (k) cnt[c] = s ? 1 : 0;
            else if (s) cnt[c] = (cnt[c] + 1 > MAXV) ? MAXV : cnt[c] + 1;
        end
        expPulse = inject;
        expFlag  = inject ? 1'b1 : (seuClr ? 1'b0 : expFlag);
        #1;
        checkAll(tag);
    endtask

    task automatic modelReset();
        for (int c = 0; c < N_CH; c++) cnt[c] = 0;
        expData  = 0;
        expSat   = 1'b0;
        expValid = 1'b0;
        expPulse = 1'b0;
        expFlag  = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus.L1          = 1'b0;
        bus.L1_Reg_Full = '0;
        bus.ReadReq     = 1'b0;
        bus.ReadCh      = '0;
        bus.SeuClear    = 1'b0;
        rst_n = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < N_CH; c++) applyStimulus("t1_read", 0, '0, 1, c, 0, 0);

        repeat (10) applyStimulus("t2_skip", 1, 4'b0001, 0, 0, 0, 0);
        applyStimulus("t2_read", 0, '0, 1, 0, 0, 0);
        checkOutput("t2_count10", 32'(bus.ReadData), 32'd10);
        applyStimulus("t2_reread", 0, '0, 1, 0, 0, 0);
        for (int c = 1; c < N_CH; c++) applyStimulus("t2_other", 0, '0, 1, c, 0, 0);

        repeat (5) applyStimulus("t3_nofull", 1, '0, 0, 0, 0, 0);

        repeat (300) applyStimulus("t4_sat", 1, 4'b0100, 0, 0, 0, 0);
        applyStimulus("t4_read", 0, '0, 1, 2, 0, 0);
        checkOutput("t4_sat255", 32'(bus.ReadData), 32'd255);
        applyStimulus("t4_reread", 0, '0, 1, 2, 0, 0);

        repeat (5) applyStimulus("t5_skip", 1, 4'b0010, 0, 0, 0, 0);
        applyStimulus("t5_collide", 1, 4'b0010, 1, 1, 0, 0);
        checkOutput("t5_count5", 32'(bus.ReadData), 32'd5);
        applyStimulus("t5_next", 0, '0, 1, 1, 0, 0);
        checkOutput("t5_count1", 32'(bus.ReadData), 32'd1);

        repeat (4) applyStimulus("t6_skip", 1, 4'b1000, 0, 0, 0, 0);
        applyStimulus("t6_upset_read", 0, '0, 1, 3, 0, 1);
        checkOutput("t6_voted4", 32'(bus.ReadData), 32'd4);
        checkOutput("t6_scrubbed", 32'(dut.g_ch[3].u_cnt.copy1_q), 32'(cnt[3]));
        repeat (3) applyStimulus("t6_sticky", 0, '0, 0, 0, 0, 0);
        applyStimulus("t6_clear", 0, '0, 0, 0, 1, 0);
        applyStimulus("t6_setwins", 0, '0, 0, 0, 1, 1);
        applyStimulus("t6_clear2", 0, '0, 0, 0, 1, 0);

        for (int i = 0; i < 300; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 1)), N_CH'($urandom),
                          ($urandom_range(0, 2) == 0), int'($urandom_range(0, N_CH - 1)),
                          ($urandom_range(0, 7) == 0), 0);
        end

        // A read request caught by reset must not produce ReadValid.
        @(negedge clk);
        bus.ReadReq = 1'b1;
        bus.ReadCh  = '0;
        #1 rst_n = 1'b0;
        modelReset();
        #1;
        checkAll("rst_inflight");
        @(negedge clk);
        bus.ReadReq = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkAll("rst_release");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
